// File: rtl/mem_request_responder_pkg.sv
// Shared types for the memory request responder and the IO front end that feeds it.
// Holds the request mode encoding, the responder state set and default bus widths.
package mem_ctrl_pkg;

  localparam int unsigned AddrWDefault = 25;
  localparam int unsigned DataWDefault = 16;

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_IDLE  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CLEAR,
    DONE
  } rsp_state_e;

endpackage

// File: rtl/mem_request_responder_if.sv
// Generic req/ack memory port. master = responder side, slave = memory side.
interface mem_request_responder_if
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) ();

  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              memAck;
  logic [DATA_W-1:0] memRdata;

  modport master (
    output memReq, memWe, memAddr, memWdata,
    input  memAck, memRdata
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata,
    output memAck, memRdata
  );

endinterface

// File: rtl/mem_request_responder_watchdog.sv
// Ack watchdog: counts cycles spent waiting on memAck and flags expiry on the
// TIMEOUT_CYCLES-th consecutive unacknowledged cycle. Used only with MEM_TIMEOUT_EN.
module mem_ack_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of already-completed unacknowledged cycles
  assign expired = active & ~ack & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!active || ack) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_request_responder.sv
// Memory-side responder: one clear/read/write request per ioDone rising edge, run on a
// req/ack memory port. Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_request_responder
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = AddrWDefault,
  parameter int unsigned DATA_W         = DataWDefault,
  parameter int unsigned CLEAR_WORDS    = 2 ** 25,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              modeInput,
  input  logic                    ioDone,
  input  logic [24:0]             memoryAddress,
  input  logic [DATA_W-1:0]       ioDataOut,
  output logic                    memDone,
  output logic [DATA_W-1:0]       readData,
  output logic                    readValid,
  output logic                    errFlag,
  mem_request_responder_if.master mem
);

  rsp_state_e        state_q, state_d;
  logic              io_done_q, io_done_d;
  logic              mem_done_q, mem_done_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;
  logic              req_pulse, accept, wdg_expired;

  assign req_pulse = ioDone & ~io_done_q;

  always_comb begin
    state_d      = state_q;
    io_done_d    = ioDone;
    mem_done_d   = mem_done_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    accept       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_pulse && (mode_e'(modeInput) != MODE_IDLE)) begin
          accept      = 1'b1;
          mem_done_d  = 1'b0;
          mem_req_d   = 1'b1;
          mem_addr_d  = memoryAddress[ADDR_W-1:0];
          mem_wdata_d = ioDataOut;
          unique case (mode_e'(modeInput))
            MODE_WRITE: begin
              state_d  = WRITE;
              mem_we_d = 1'b1;
            end
            MODE_READ: begin
              state_d  = READ;
              mem_we_d = 1'b0;
            end
            default: begin
              // Clear sweep: zero data from word 0 upward
              state_d     = CLEAR;
              mem_we_d    = 1'b1;
              mem_addr_d  = '0;
              mem_wdata_d = '0;
            end
          endcase
        end
      end
      WRITE, READ: begin
        if (mem.memAck) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          mem_done_d = 1'b1;
          if (state_q == READ) begin
            read_data_d  = mem.memRdata;
            read_valid_d = 1'b1;
          end
        end else if (wdg_expired) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          mem_done_d = 1'b1;
        end
      end
      CLEAR: begin
        if (mem.memAck) begin
          if (mem_addr_q == ADDR_W'(CLEAR_WORDS - 1)) begin
            state_d    = DONE;
            mem_req_d  = 1'b0;
            mem_done_d = 1'b1;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end else if (wdg_expired) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          mem_done_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      io_done_q    <= 1'b0;
      mem_done_q   <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      io_done_q    <= io_done_d;
      mem_done_q   <= mem_done_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic err_q, err_d;

  mem_ack_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active (mem_req_q),
    .ack    (mem.memAck),
    .expired(wdg_expired)
  );

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (wdg_expired) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign errFlag = err_q;
`else
  assign wdg_expired = 1'b0;
  assign errFlag     = 1'b0;
`endif

  assign memDone      = mem_done_q;
  assign readData     = read_data_q;
  assign readValid    = read_valid_q;
  assign mem.memReq   = mem_req_q;
  assign mem.memWe    = mem_we_q;
  assign mem.memAddr  = mem_addr_q;
  assign mem.memWdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_request_responder.sv
// Randomized self-checking bench for mem_request_responder against a word-level memory model.
// Watchdog expectations follow MEM_TIMEOUT_EN.
module tb_mem_request_responder;
  import mem_ctrl_pkg::*;

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned TO = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    modeInput = 2'b11;
  logic          ioDone = 1'b0;
  logic [24:0]   memoryAddress = '0;
  logic [DW-1:0] ioDataOut = '0;
  logic          memDone, readValid, errFlag;
  logic [DW-1:0] readData;

  mem_request_responder_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  mem_request_responder #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .CLEAR_WORDS   (CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .modeInput    (modeInput),
    .ioDone       (ioDone),
    .memoryAddress(memoryAddress),
    .ioDataOut    (ioDataOut),
    .memDone      (memDone),
    .readData     (readData),
    .readValid    (readValid),
    .errFlag      (errFlag),
    .mem          (mem_bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int ack_delay = 0;
  int busy_cycles, rv_count, req_cycles;
  logic rv_at_done;
  logic [DW-1:0] dev_mem [int];
  logic [DW-1:0] model_mem [int];
  xfer_t xlog [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dev_rd(input int a);
    return dev_mem.exists(a) ? dev_mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] model_rd(input int a);
    return model_mem.exists(a) ? model_mem[a] : '0;
  endfunction

  // Memory: ack after ack_delay unacknowledged request cycles; the transfer lands at the next edge
  initial begin : memory_model
    int wait_cnt;
    wait_cnt = 0;
    mem_bus.memAck   = 1'b0;
    mem_bus.memRdata = '0;
    forever begin
      @(negedge clk);
      if (mem_bus.memReq && wait_cnt >= ack_delay) begin
        mem_bus.memAck   = 1'b1;
        mem_bus.memRdata = dev_rd(int'(mem_bus.memAddr));
        xlog.push_back('{we: mem_bus.memWe, addr: mem_bus.memAddr, data: mem_bus.memWdata});
        if (mem_bus.memWe) dev_mem[int'(mem_bus.memAddr)] = mem_bus.memWdata;
        wait_cnt = 0;
      end else begin
        mem_bus.memAck = 1'b0;
        wait_cnt = mem_bus.memReq ? wait_cnt + 1 : 0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!memDone) busy_cycles++;
      if (readValid) rv_count++;
      if (mem_bus.memReq) req_cycles++;
    end
  end

  task automatic run_req(input logic [1:0] mode, input logic [24:0] a, input logic [DW-1:0] d,
                         input int dly, input int hold, input int budget);
    @(negedge clk);
    ack_delay = dly;
    busy_cycles = 0;
    rv_count = 0;
    req_cycles = 0;
    xlog.delete();
    modeInput = mode;
    memoryAddress = a;
    ioDataOut = d;
    ioDone = 1'b1;
    repeat (hold) @(negedge clk);
    ioDone = 1'b0;
    for (int i = 0; i < budget && !memDone; i++) @(negedge clk);
    check_eq("done_wait", memDone, 1'b1);
    rv_at_done = readValid;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_write(input logic [24:0] a, input logic [DW-1:0] d, input int dly);
    run_req(MODE_WRITE, a, d, dly, 1, 200);
    model_mem[int'(a)] = d;
    check_eq("wr_count", xlog.size(), 1);
    if (xlog.size() > 0) check_eq("wr_xfer", xlog[0], {1'b1, a, d});
    check_eq("wr_busy", busy_cycles, dly + 1);
    check_eq("wr_rvalid", rv_count, 0);
  endtask

  task automatic do_read(input logic [24:0] a, input int dly);
    run_req(MODE_READ, a, $urandom, dly, 1, 200);
    check_eq("rd_data", readData, model_rd(int'(a)));
    check_eq("rd_count", xlog.size(), 1);
    if (xlog.size() > 0) check_eq("rd_xfer", {xlog[0].we, xlog[0].addr}, {1'b0, a});
    check_eq("rd_busy", busy_cycles, dly + 1);
    check_eq("rd_rvalid", rv_count, 1);
    check_eq("rd_rv_at_done", rv_at_done, 1'b1);
  endtask

  task automatic do_clear(input int dly);
    run_req(MODE_CLEAR, $urandom, $urandom, dly, 1, 400);
    for (int i = 0; i < int'(CW); i++) model_mem[i] = '0;
    check_eq("clr_count", xlog.size(), CW);
    for (int i = 0; i < xlog.size() && i < int'(CW); i++)
      check_eq("clr_xfer", xlog[i], {1'b1, AW'(i), DW'(0)});
    check_eq("clr_req_cycles", req_cycles, CW * (dly + 1));
    check_eq("clr_busy", busy_cycles, CW * (dly + 1));
  endtask

  initial begin : global_limit
    #500000;
    $display("FAIL global_limit: got=running exp=finished");
    $fatal(1);
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_memDone", memDone, 1'b1);
    check_eq("rst_memReq", mem_bus.memReq, 1'b0);
    check_eq("rst_memWe", mem_bus.memWe, 1'b0);
    check_eq("rst_memAddr", mem_bus.memAddr, '0);
    check_eq("rst_memWdata", mem_bus.memWdata, '0);
    check_eq("rst_readData", readData, '0);
    check_eq("rst_readValid", readValid, 1'b0);
    check_eq("rst_errFlag", errFlag, 1'b0);

    do_write(25'h0_1234, 16'hBEEF, 2);
    do_read(25'h0_1234, 0);
    do_clear(0);

    // ioDone held high for 20 cycles: exactly one transfer
    run_req(MODE_WRITE, 25'h9, 16'h1357, 1, 20, 200);
    model_mem[9] = 16'h1357;
    check_eq("hold_count", xlog.size(), 1);
    check_eq("hold_busy", busy_cycles, 2);

    // Second edge while busy is dropped
    @(negedge clk);
    ack_delay = 8;
    xlog.delete();
    modeInput = MODE_WRITE;
    memoryAddress = 25'hA;
    ioDataOut = 16'h2468;
    ioDone = 1'b1;
    @(negedge clk);
    ioDone = 1'b0;
    repeat (2) @(negedge clk);
    modeInput = MODE_READ;
    memoryAddress = 25'hB;
    ioDone = 1'b1;
    @(negedge clk);
    ioDone = 1'b0;
    for (int i = 0; i < 100 && !memDone; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    model_mem[10] = 16'h2468;
    check_eq("busy_edge_count", xlog.size(), 1);
    if (xlog.size() > 0) check_eq("busy_edge_xfer", xlog[0], {1'b1, 25'hA, 16'h2468});

    // Idle mode: no memory activity
    run_req(MODE_IDLE, 25'h3, 16'hFFFF, 0, 1, 10);
    repeat (3) @(negedge clk);
    check_eq("idle_req", req_cycles, 0);
    check_eq("idle_busy", busy_cycles, 0);

    do_write(25'h4, 16'hC0DE, 0);
    do_read(25'h4, 1);

    // Reset while the clear sweep is on address 3
    @(negedge clk);
    ack_delay = 2;
    modeInput = MODE_CLEAR;
    ioDone = 1'b1;
    @(negedge clk);
    ioDone = 1'b0;
    for (int i = 0; i < 100 && !(mem_bus.memReq && mem_bus.memAddr == 3); i++) @(negedge clk);
    check_eq("mid_clr_addr", mem_bus.memAddr, 25'h3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) model_mem[i] = '0;
    check_eq("mid_rst_memReq", mem_bus.memReq, 1'b0);
    check_eq("mid_rst_memDone", memDone, 1'b1);
    check_eq("mid_rst_readData", readData, '0);
    do_write(25'h3, 16'hA5A5, 1);
    do_read(25'h2, 0);
    do_read(25'h4, 0);

    for (int n = 0; n < 24; n++) begin
      int sel;
      logic [24:0] a;
      sel = $urandom_range(0, 9);
      a = 25'($urandom_range(0, 15));
      if (sel < 5) do_write(a, DW'($urandom), $urandom_range(0, 3));
      else if (sel < 9) do_read(a, $urandom_range(0, 3));
      else do_clear($urandom_range(0, 1));
    end

`ifdef MEM_TIMEOUT_EN
    run_req(MODE_WRITE, 25'h5, 16'h1111, 1000, 1, 100);
    check_eq("to_req_cycles", req_cycles, TO);
    check_eq("to_errFlag", errFlag, 1'b1);
    check_eq("to_memReq", mem_bus.memReq, 1'b0);
    check_eq("to_rvalid", rv_count, 0);
    check_eq("to_count", xlog.size(), 0);
    do_write(25'h5, 16'h2222, 1);
    check_eq("to_err_cleared", errFlag, 1'b0);
    do_read(25'h5, 0);
`else
    @(negedge clk);
    ack_delay = 1000;
    modeInput = MODE_WRITE;
    memoryAddress = 25'h5;
    ioDone = 1'b1;
    @(negedge clk);
    ioDone = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("hang_memReq", mem_bus.memReq, 1'b1);
    check_eq("hang_memDone", memDone, 1'b0);
    check_eq("hang_errFlag", errFlag, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("hang_rst_memReq", mem_bus.memReq, 1'b0);
    do_write(25'h5, 16'h2222, 1);
    do_read(25'h5, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
